// File: rtl/mc_alu_seq.sv
// mc_alu_seq: sequenced ALU with registered result/flags, start/busy/done handshake and optional iterative multiplier (MC_ALU_MUL_EN).
//   in : clk, reset (async, active-high), start, op[3:0], alu_src_a, alu_src_b[1:0], a, b, pc [WIDTH], imm [IMM_W]
//   out: busy, done, result[WIDTH], flag_n, flag_z, flag_c, flag_v, flag (= flag_n)
module mc_alu_seq #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             alu_src_a,
  input  logic [1:0]       alu_src_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [IMM_W-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag
);
  localparam int SH_W = $clog2(WIDTH);
  logic [WIDTH-1:0] src_a, src_b, imm_x, opnd_b, res, fin_res, out;
  logic [WIDTH:0] sum;
  logic [SH_W-1:0] sh;
  logic sub, c, v, issue, fin;
  assign imm_x = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign src_a = alu_src_a ? a : pc;
  assign src_b = alu_src_b == 2'd0 ? b : alu_src_b == 2'd1 ? WIDTH'(1) : alu_src_b == 2'd2 ? imm_x : '0;
  assign sh = src_b[SH_W-1:0];
  // SUB is A + ~B + 1, so ADD and SUB share one adder and one overflow rule
  assign sub = op == 4'd1;
  assign opnd_b = sub ? ~src_b : src_b;
  assign sum = {1'b0, src_a} + {1'b0, opnd_b} + {{WIDTH{1'b0}}, sub};
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (src_a[WIDTH-1] == opnd_b[WIDTH-1]) && (res[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'd2: res = src_a & src_b;
      4'd3: res = src_a | src_b;
      4'd4: res = src_a ^ src_b;
      4'd5: res = src_a << sh;
      4'd6: res = src_a >> sh;
      4'd7: res = $signed(src_a) >>> sh;
      default: res = '0;
    endcase
  end
`ifdef MC_ALU_MUL_EN
  localparam logic [0:0] IDLE = 1'b0, MULT = 1'b1;
  logic [0:0] state;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [SH_W-1:0] cnt;
  logic go_mul;
  assign go_mul = state == IDLE && start && op == 4'd8;
  assign issue = state == IDLE && start && op != 4'd8;
  assign fin = state == MULT && cnt == SH_W'(WIDTH-1);
  assign fin_res = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (go_mul) begin
      state <= MULT;
      mcand <= src_a;
      mplier <= src_b;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b1;
    end else if (state == MULT) begin
      acc <= fin_res;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + SH_W'(1);
      state <= fin ? IDLE : MULT;
      busy <= ~fin;
    end
`else
  assign issue = start;
  assign fin = 1'b0;
  assign fin_res = '0;
  assign busy = 1'b0;
`endif
  assign out = fin ? fin_res : res;
  assign flag = flag_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      done <= 1'b0;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      done <= issue | fin;
      if (issue | fin) begin
        result <= out;
        flag_n <= out[WIDTH-1];
        flag_z <= ~|out;
        flag_c <= c & ~fin;
        flag_v <= v & ~fin;
      end
    end
endmodule

// File: tb/tb_mc_alu_seq.sv
// tb_mc_alu_seq: scoreboard bench for mc_alu_seq (WIDTH=16, IMM_W=7); expectations queued at issue, checked by a done monitor.
module tb_mc_alu_seq;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, alu_src_a = 1'b0;
  logic [3:0] op = '0;
  logic [1:0] alu_src_b = '0;
  logic [15:0] a = '0, b = '0, pc = '0;
  logic [6:0] imm = '0;
  logic busy, done, flag_n, flag_z, flag_c, flag_v, flag;
  logic [15:0] result;
  int n_pass = 0, n_tot = 0;
  logic [19:0] exp_q[$];
  string name_q[$];
  logic [19:0] mon_e;
  string mon_nm;

  mc_alu_seq #(.WIDTH(16), .IMM_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .a(a), .b(b), .pc(pc), .imm(imm), .busy(busy),
    .done(done), .result(result), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v), .flag(flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  task automatic drive(input logic [3:0] o, input logic sa, input logic [1:0] sb,
                       input logic [15:0] va, input logic [15:0] vb, input logic [15:0] vpc,
                       input logic [6:0] vi);
    op = o; alu_src_a = sa; alu_src_b = sb; a = va; b = vb; pc = vpc; imm = vi; start = 1'b1;
  endtask

  task automatic issue(input string nm, input logic [3:0] o, input logic sa, input logic [1:0] sb,
                       input logic [15:0] va, input logic [15:0] vb, input logic [15:0] vpc,
                       input logic [6:0] vi, input logic [15:0] r, input logic [3:0] nzcv);
    drive(o, sa, sb, va, vb, vpc, vi);
    exp_q.push_back({r, nzcv});
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({nm, " done"}, done, 1);
  endtask

  always @(negedge clk)
    if (!reset && done) begin
      if (exp_q.size() == 0) check("spurious done", done, 0);
      else begin
        mon_e = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        check(mon_nm, {result, flag_n, flag_z, flag_c, flag_v}, mon_e);
        check({mon_nm, " flag"}, flag, mon_e[3]);
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int cyc, bcnt;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset outputs", {busy, done, result, flag_n, flag_z, flag_c, flag_v, flag}, 0);
    reset = 1'b0;
    @(negedge clk);
    issue("add ovf",     4'd0,  1'b1, 2'd0, 16'h7FFF, 16'h0001, 16'h0000, 7'h00, 16'h8000, 4'b1001);
    issue("sub imm",     4'd1,  1'b1, 2'd2, 16'h0003, 16'h1234, 16'h0000, 7'h7F, 16'h0004, 4'b0000);
    issue("pc plus 1",   4'd0,  1'b0, 2'd1, 16'h5555, 16'h0000, 16'h0010, 7'h00, 16'h0011, 4'b0000);
    issue("sra mask",    4'd7,  1'b1, 2'd0, 16'h8001, 16'h0011, 16'h0000, 7'h00, 16'hC000, 4'b1000);
    issue("reserved 12", 4'd12, 1'b1, 2'd0, 16'h1234, 16'h5678, 16'h0000, 7'h00, 16'h0000, 4'b0100);
    issue("sub equal",   4'd1,  1'b1, 2'd0, 16'h0005, 16'h0005, 16'h0000, 7'h00, 16'h0000, 4'b0110);
    issue("add carry",   4'd0,  1'b1, 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 7'h00, 16'h0000, 4'b0110);
    issue("sub ovf",     4'd1,  1'b1, 2'd0, 16'h8000, 16'h0001, 16'h0000, 7'h00, 16'h7FFF, 4'b0011);
    issue("and",         4'd2,  1'b1, 2'd0, 16'hF0F0, 16'hFF00, 16'h0000, 7'h00, 16'hF000, 4'b1000);
    issue("or",          4'd3,  1'b1, 2'd0, 16'hF0F0, 16'hFF00, 16'h0000, 7'h00, 16'hFFF0, 4'b1000);
    issue("xor",         4'd4,  1'b1, 2'd0, 16'hF0F0, 16'hFF00, 16'h0000, 7'h00, 16'h0FF0, 4'b0000);
    issue("sll mask",    4'd5,  1'b1, 2'd0, 16'h0001, 16'h0013, 16'h0000, 7'h00, 16'h0008, 4'b0000);
    issue("srl",         4'd6,  1'b1, 2'd0, 16'h8000, 16'h000F, 16'h0000, 7'h00, 16'h0001, 4'b0000);
    issue("srcb zero",   4'd0,  1'b1, 2'd3, 16'h1234, 16'hFFFF, 16'h0000, 7'h00, 16'h1234, 4'b0000);
`ifdef MC_ALU_MUL_EN
    drive(4'd8, 1'b1, 2'd0, 16'h0123, 16'h0045, 16'h0000, 7'h00);
    exp_q.push_back({16'h4E6F, 4'b0000});
    name_q.push_back("mul");
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      start = cyc[0];
      op = 4'd0;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("mul busy cycles", bcnt, 16);
    check("mul done edge", cyc, 16);
    check("mul busy at done", busy, 0);
    issue("b2b add", 4'd0, 1'b1, 2'd0, 16'h0001, 16'h0002, 16'h0000, 7'h00, 16'h0003, 4'b0000);
    drive(4'd8, 1'b1, 2'd0, 16'h0123, 16'h0045, 16'h0000, 7'h00);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy mid mul", busy, 1);
`else
    drive(4'd8, 1'b1, 2'd0, 16'h0123, 16'h0045, 16'h0000, 7'h00);
    exp_q.push_back({16'h0000, 4'b0100});
    name_q.push_back("mul disabled");
    @(posedge clk);
    #1 check("mul disabled busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("mul disabled done", done, 1);
    check("mul disabled busy later", busy, 0);
    issue("add after", 4'd0, 1'b1, 2'd0, 16'h0001, 16'h0002, 16'h0000, 7'h00, 16'h0003, 4'b0000);
`endif
    #2 reset = 1'b1;
    #1 check("async reset outputs", {busy, done, result, flag_n, flag_z, flag_c, flag_v, flag}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no done after abort", {done, result}, 0);
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mc_alu_seq.md
Name: mc_alu_seq

Overview:
- Parametrised, sequenced successor to the processor's combinational ALU.
- Generalised datapath:
  - WIDTH-bit operands
  - IMM_W-bit sign-extended immediate
  - 4-bit opcode covering arithmetic, logic and shifts
  - iterative shift-add multiplier
- Registered result and N/Z/C/V flags.
- Sits in the multi-cycle datapath between the register-file/PC read stage and the ALUOut register. The controller drives it with a start/busy/done handshake.

Parameters:
- WIDTH, 16: operand/result width; must be ≥ 4 and a power of two.
- IMM_W, 7: immediate field width; sign-extended to WIDTH.
- SH_W, log2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL; 9–15 reserved.
- alu_src_a  in  1  1 = A, 0 = PC.
- alu_src_b  in  2  00 = B, 01 = constant 1, 10 = sign-extended imm, 11 = 0.
- a  in  WIDTH  register operand A.
- b  in  WIDTH  register operand B.
- pc  in  WIDTH  program counter.
- imm  in  IMM_W  immediate.
- busy  out  1  high while a multiply iterates.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  registered result; held until the next done.
- flag_n, flag_z, flag_c, flag_v  out  1 each  registered flags, updated with result.
- flag  out  1  equals flag_n; kept for the existing branch logic.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state = IDLE
  - result = 0
  - all flags = 0, busy = 0, done = 0
  - multiplier registers = 0
- Reset mid-multiply aborts the operation. No done is produced.
- Operand muxing, combinational on the inputs in the start cycle:
  - SrcA = alu_src_a ? a : pc
  - SrcB selected per alu_src_b
  - Sign extension replicates imm[IMM_W-1].
- States:
  - IDLE:
    - start=1 with op≠8: compute at this edge; result and flags register; done=1 in the next cycle; stay IDLE. Latency is 1 edge.
    - start=1 with op=8: latch multiplicand = SrcA, multiplier = SrcB, accumulator = 0, count = 0; go to MULT; busy=1.
  - MULT:
    - Each edge: if multiplier[0], accumulator += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; count++.
    - On the edge where count == WIDTH-1: result = final accumulator (low WIDTH bits of the product); done=1; busy=0; return to IDLE.
    - Latency is WIDTH+1 edges from the start-sampling edge.
    - start is ignored in MULT.
- done is high for exactly one cycle. start may be asserted during the done cycle (back-to-back, because state is IDLE).
- Arithmetic is modulo 2^WIDTH.
  - ADD: C = carry out; V = (SrcA and SrcB signs equal) and (result sign differs).
  - SUB: computed as SrcA + ~SrcB + 1. C = carry out (1 means no borrow). V = (SrcA and SrcB signs differ) and (result sign ≠ SrcA sign).
- Shifts use SrcB[SH_W-1:0] only; upper bits are ignored. SRA replicates the MSB.
- Logic ops, shifts and MUL: C = 0, V = 0.
- All ops: N = result[WIDTH-1]; Z = (result == 0).
- Reserved opcodes: result 0, Z = 1, all other flags 0, latency 1.
- Flags and result change only on the edge that raises done.

Optional Feature:
- Macro: MC_ALU_MUL_EN.
- Defined: MULT state and the iterative multiplier are built as described above.
- Undefined:
  - No MULT state and no multiplier registers.
  - op 8 is treated as reserved: result 0, Z = 1, latency 1.
  - busy is tied to 0.

Test Plan (WIDTH=16, IMM_W=7):
- Reset: assert reset asynchronously mid-MULT (cycle 5) → busy, done, result and flags go 0 immediately; no done pulse after release.
- ADD overflow: a=0x7FFF, b=0x0001, src_a=1, src_b=00, op=0 → one cycle later done=1, result=0x8000, N=1, V=1, C=0, Z=0.
- SUB sign-extended immediate: a=0x0003, imm=7'h7F (−1), src_b=10, op=1 → result=0x0004, C=0, V=0. Separately, pc=0x0010, src_a=0, src_b=01, op=0 → result=0x0011.
- Shift masking: a=0x8001, b=0x0011, op=7 (SRA) → shift by 1; result=0xC000, N=1.
- MUL: a=0x0123, b=0x0045, op=8 → busy high for 16 cycles, start pulses ignored meanwhile; done on edge 17 with result=0x4E6F. Back-to-back ADD issued in the done cycle completes on the following edge.
- Reserved and macro-off: op=12 → result 0, Z=1. With MC_ALU_MUL_EN undefined, op=8 → done after 1 edge, result 0, busy never high.
